ibex_rf_ecc_scrubber: RTL and testbench
=======================================

# ibex_rf_ecc_scrubber

Background scrubber for the SEC-DED (39,32) protected flip-flop register file. It walks registers x1..x(NumWords-1) on a fixed interval and reads each raw codeword over a dedicated scrub read port. Single-bit errors are written back corrected through the shared write port, and only in cycles the core is not writing. Uncorrectable errors are flagged and counted; the block sits beside the register file and is enabled from the core's configuration logic.

## Interface
- NumWords, 32: register count including x0 (16 for RV32E); x0 is never scrubbed.
- ScrubInterval, 1024: cycles between the start of successive register checks; must be ≥ 4.
- CntWidth, 8: width of error counters.
- clk  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  scrub enable.
- core_we_i  in  1  core write strobe to the register file; has priority over scrub writes.
- core_waddr_i  in  5  core write address.
- scrub_raddr_o  out  5  scrub read address; the register file returns data combinationally.
- scrub_rdata_i  in  39  raw codeword at scrub_raddr_o; bits 38:32 are check bits.
- scrub_we_o  out  1  scrub write strobe, only when core_we_i=0.
- scrub_waddr_o  out  5  scrub write address.
- scrub_wdata_o  out  39  corrected codeword.
- busy_o  out  1  high in any state other than IDLE.
- uncorr_err_o  out  1  one-cycle pulse on detection of an uncorrectable word.
- corr_cnt_o  out  CntWidth  saturating count of corrected words.
- uncorr_cnt_o  out  CntWidth  saturating count of uncorrectable words.

## Operation
- FSM states: IDLE, READ, CHECK, WB.
- IDLE: the interval counter loads ScrubInterval-1 and counts down while en_i=1. At 0 it moves to READ. With en_i=0 the counter is held reloaded.
- READ: scrub_raddr_o=ptr. scrub_rdata_i is captured into a 39-bit register. Next state is CHECK.
- CHECK: classify the captured word by syndrome. The syndrome is the data-bit parities XOR the check bits, using the same column set as the write encoder.
  - Syndrome 0: clean. Advance ptr and return to IDLE.
  - Syndrome equal to one of the 39 H-matrix columns: correctable. Flip the matching bit to form the corrected word. Next state is WB.
  - Any other nonzero syndrome (even weight, or odd weight with no matching column): uncorrectable. Pulse uncorr_err_o, increment uncorr_cnt_o, advance ptr, return to IDLE. No write.
- WB: scrub_we_o=1 in the first cycle with core_we_i=0, with scrub_waddr_o=ptr and scrub_wdata_o=the corrected word. In that same cycle, increment corr_cnt_o, advance ptr and return to IDLE. While core_we_i=1 to another address, WB waits.
- Collision:
  - Condition: in READ, CHECK or WB, core_we_i=1 with core_waddr_i==ptr.
  - Effect: sets a sticky abort. In WB the abort takes effect the same cycle.
  - Result: no scrub write and no counter change; advance ptr and return to IDLE. The core's data is newer.
- Pointer: resets to 1, increments to NumWords-1, then wraps to 1.
- en_i deasserted mid-sequence: the in-flight check completes normally; the block then stays in IDLE.
- Counters saturate at 2^CntWidth-1 and never wrap.

## Timing
- Reset values:
  - state IDLE, ptr 1, interval counter ScrubInterval-1.
  - All outputs 0, except scrub_raddr_o, which equals ptr (1).
- Minimum latency from counter expiry to scrub write: READ 1 cycle, CHECK 1 cycle, WB 1 cycle. The write occurs in the 3rd cycle after leaving IDLE.
- The interval counter restarts on re-entry to IDLE, so the check period is ScrubInterval plus 2 or 3 cycles, plus any WB stall.
- scrub_we_o and core_we_i are never high in the same cycle.
- uncorr_err_o is high for exactly one cycle, in the CHECK cycle.
- Reset asserted mid-sequence: immediate return to reset values; no partial write.

## Structure
- Shared package (ibex_pkg or a new ibex_ecc_pkg) holds:
  - the 39 H-matrix column constants as a localparam array;
  - the syndrome-classification enum (CLEAN, CORR, UNCORR);
  - the FSM state typedef.
- One natural sub-module: ibex_secded_39_32_check. It is purely combinational: input 39-bit word; outputs syndrome, class and corrected 39-bit word. The read-path decoders can reuse it.

## Test plan
- Clean file, ScrubInterval=8, en_i=1: ptr visits 1..31 then 1. No scrub_we_o; counters stay 0.
- Word in x5 with data bit 3 flipped: at x5's check, scrub_we_o=1, scrub_waddr_o=5, scrub_wdata_o=original codeword; corr_cnt_o=1.
- x7 with bits 0 and 1 flipped (even syndrome): uncorr_err_o pulses once; uncorr_cnt_o=1; no write; ptr moves to 8.
- Correctable error in x9, with core_we_i=1 to x12 during WB for 3 cycles: scrub write occurs in the first cycle with core_we_i=0, with correct data. Repeat with core_waddr_i=9 during CHECK: no scrub write; corr_cnt_o unchanged.
- Force 260 corrections with CntWidth=8: corr_cnt_o holds at 255.
- Assert rst_ni=0 during WB: scrub_we_o=0 immediately; after release, ptr=1 and counters are 0.

Source files
------------

// File: rtl/ibex_ecc_pkg.sv
// Shared SEC-DED (39,32) definitions for the register-file ECC path:
// H-matrix columns, syndrome classes, scrubber FSM states and the encoder.
package ibex_ecc_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned EccWidth  = 39;
    localparam int unsigned SynWidth  = 7;

    // Data columns are the first 32 weight-3 vectors in ascending order; check
    // columns are unit vectors, so every column is odd weight and any double
    // error leaves an even, nonzero syndrome.
    localparam logic [SynWidth-1:0] HCol [EccWidth] = '{
        7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
        7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
        7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
        7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62,
        7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40
    };

    typedef enum logic [1:0] {
        CLEAN,
        CORR,
        UNCORR
    } ecc_class_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CHECK,
        WB
    } scrub_state_e;

    function automatic logic [EccWidth-1:0] ecc_encode(input logic [DataWidth-1:0] data);
        logic [SynWidth-1:0] chk;
        chk = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (data[i]) chk ^= HCol[i];
        end
        return {chk, data};
    endfunction

endpackage

// File: rtl/ibex_secded_39_32_check.sv
// Combinational SEC-DED (39,32) checker: syndrome, error class and the
// single-bit-corrected codeword.
module ibex_secded_39_32_check
    import ibex_ecc_pkg::*;
(
    input  logic [EccWidth-1:0] i_word,
    output logic [SynWidth-1:0] o_syndrome,
    output ecc_class_e          o_class,
    output logic [EccWidth-1:0] o_corrected
);

    logic [SynWidth-1:0] w_syn;
    logic [EccWidth-1:0] w_flip;

    always_comb begin
        w_syn = '0;
        for (int i = 0; i < EccWidth; i++) begin
            if (i_word[i]) w_syn ^= HCol[i];
        end
    end

    // Columns are distinct, so at most one bit of w_flip can be set.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < EccWidth; i++) begin
            w_flip[i] = (w_syn == HCol[i]);
        end
    end

    always_comb begin
        o_class = UNCORR;
        if (w_syn == '0) begin
            o_class = CLEAN;
        end else if (|w_flip) begin
            o_class = CORR;
        end
    end

    assign o_syndrome  = w_syn;
    assign o_corrected = i_word ^ w_flip;

endmodule

// File: rtl/ibex_rf_ecc_scrubber.sv
// Background scrubber for the ECC-protected register file: periodically reads
// x1..x(NumWords-1), writes back single-bit corrections, counts both classes.
module ibex_rf_ecc_scrubber
    import ibex_ecc_pkg::*;
#(
    parameter int unsigned NumWords      = 32,
    parameter int unsigned ScrubInterval = 1024,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                core_we_i,
    input  logic [4:0]          core_waddr_i,
    output logic [4:0]          scrub_raddr_o,
    input  logic [38:0]         scrub_rdata_i,
    output logic                scrub_we_o,
    output logic [4:0]          scrub_waddr_o,
    output logic [38:0]         scrub_wdata_o,
    output logic                busy_o,
    output logic                uncorr_err_o,
    output logic [CntWidth-1:0] corr_cnt_o,
    output logic [CntWidth-1:0] uncorr_cnt_o
);

    localparam int unsigned         IntW      = $clog2(ScrubInterval);
    localparam logic [IntW-1:0]     IntReload = IntW'(ScrubInterval - 1);
    localparam logic [4:0]          LastPtr   = 5'(NumWords - 1);
    localparam logic [CntWidth-1:0] CntMax    = '1;

    scrub_state_e        r_state, w_state_nxt;
    logic [4:0]          r_ptr;
    logic [IntW-1:0]     r_int_cnt;
    logic [38:0]         r_word;
    logic                r_abort;
    logic [CntWidth-1:0] r_corr_cnt, r_uncorr_cnt;

    logic [SynWidth-1:0] w_syndrome;
    ecc_class_e          w_class;
    logic [38:0]         w_corrected;
    logic                w_collide, w_abort, w_advance, w_scrub_we, w_uncorr_pulse;

    ibex_secded_39_32_check u_check (
        .i_word      (r_word),
        .o_syndrome  (w_syndrome),
        .o_class     (w_class),
        .o_corrected (w_corrected)
    );

    // A core write to the word in flight makes our copy stale.
    assign w_collide = core_we_i && (core_waddr_i == r_ptr);
    assign w_abort   = r_abort || w_collide;

    always_comb begin
        w_state_nxt    = r_state;
        w_advance      = 1'b0;
        w_scrub_we     = 1'b0;
        w_uncorr_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (en_i && r_int_cnt == '0) w_state_nxt = READ;
            end
            READ: begin
                w_state_nxt = CHECK;
            end
            CHECK: begin
                if (w_abort || w_syndrome == '0) begin
                    w_state_nxt = IDLE;
                    w_advance   = 1'b1;
                end else if (w_class == CORR) begin
                    w_state_nxt = WB;
                end else begin
                    w_state_nxt    = IDLE;
                    w_advance      = 1'b1;
                    w_uncorr_pulse = 1'b1;
                end
            end
            WB: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_advance   = 1'b1;
                end else if (!core_we_i) begin
                    w_scrub_we  = 1'b1;
                    w_state_nxt = IDLE;
                    w_advance   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_ptr        <= 5'd1;
            r_int_cnt    <= IntReload;
            r_word       <= '0;
            r_abort      <= 1'b0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Held reloaded outside IDLE so the interval restarts on re-entry.
            if (r_state != IDLE || !en_i) begin
                r_int_cnt <= IntReload;
            end else if (r_int_cnt != '0) begin
                r_int_cnt <= r_int_cnt - IntW'(1);
            end

            if (r_state == READ) begin
                r_word <= scrub_rdata_i;
            end else if (r_state == CHECK) begin
                r_word <= w_corrected;
            end

            if (r_state == IDLE) begin
                r_abort <= 1'b0;
            end else if (w_collide) begin
                r_abort <= 1'b1;
            end

            if (w_advance) begin
                r_ptr <= (r_ptr == LastPtr) ? 5'd1 : r_ptr + 5'd1;
            end

            if (w_scrub_we && r_corr_cnt != CntMax) begin
                r_corr_cnt <= r_corr_cnt + CntWidth'(1);
            end
            if (w_uncorr_pulse && r_uncorr_cnt != CntMax) begin
                r_uncorr_cnt <= r_uncorr_cnt + CntWidth'(1);
            end
        end
    end

    assign scrub_raddr_o = r_ptr;
    assign scrub_we_o    = w_scrub_we;
    assign scrub_waddr_o = w_scrub_we ? r_ptr : 5'd0;
    assign scrub_wdata_o = w_scrub_we ? r_word : 39'd0;
    assign busy_o        = (r_state != IDLE);
    assign uncorr_err_o  = w_uncorr_pulse;
    assign corr_cnt_o    = r_corr_cnt;
    assign uncorr_cnt_o  = r_uncorr_cnt;

endmodule

// File: tb/tb_ibex_rf_ecc_scrubber.sv
// Bench for ibex_rf_ecc_scrubber: a register-file model plus a cycle-level
// behavioural predictor, driven by directed scrub/collision/reset scenarios.
module tb_ibex_rf_ecc_scrubber;

    localparam int NW  = 32;
    localparam int SI  = 8;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          core_we_i = 1'b0;
    logic [4:0]    core_waddr_i = 5'd0;
    logic [38:0]   core_wdata = 39'd0;
    logic [4:0]    scrub_raddr_o;
    logic [38:0]   scrub_rdata_i;
    logic          scrub_we_o;
    logic [4:0]    scrub_waddr_o;
    logic [38:0]   scrub_wdata_o;
    logic          busy_o;
    logic          uncorr_err_o;
    logic [CW-1:0] corr_cnt_o;
    logic [CW-1:0] uncorr_cnt_o;

    logic [38:0] rf [NW];
    logic [6:0]  tcol [32];
    int          tests = 0;
    int          fails = 0;
    int          m_ptr, m_corr, m_uncorr;

    ibex_rf_ecc_scrubber #(.NumWords(NW), .ScrubInterval(SI), .CntWidth(CW)) dut (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .core_we_i     (core_we_i),
        .core_waddr_i  (core_waddr_i),
        .scrub_raddr_o (scrub_raddr_o),
        .scrub_rdata_i (scrub_rdata_i),
        .scrub_we_o    (scrub_we_o),
        .scrub_waddr_o (scrub_waddr_o),
        .scrub_wdata_o (scrub_wdata_o),
        .busy_o        (busy_o),
        .uncorr_err_o  (uncorr_err_o),
        .corr_cnt_o    (corr_cnt_o),
        .uncorr_cnt_o  (uncorr_cnt_o)
    );

    always #5 clk = ~clk;

    // Register file: combinational scrub read, core write last so it wins.
    assign scrub_rdata_i = rf[scrub_raddr_o];
    always @(posedge clk) begin
        if (scrub_we_o) rf[scrub_waddr_o] <= scrub_wdata_o;
        if (core_we_i)  rf[core_waddr_i]  <= core_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) if (d[i]) c ^= tcol[i];
        return {c, d};
    endfunction

    // 0 clean, 1 correctable (fix = nearest codeword), 2 uncorrectable.
    function automatic int classify(input logic [38:0] w, output logic [38:0] fix);
        logic [38:0] t;
        fix = w;
        if (w == enc(w[31:0])) return 0;
        for (int i = 0; i < 39; i++) begin
            t = w ^ (39'd1 << i);
            if (t == enc(t[31:0])) begin
                fix = t;
                return 1;
            end
        end
        return 2;
    endfunction

    function automatic int nextp(input int p);
        return (p == NW - 1) ? 1 : p + 1;
    endfunction

    // Behavioural predictor: phase 0 idle, 1 read, 2 check, 3 write-back.
    initial begin : model
        int k, ph, idle_run, mcls;
        logic abort, collide, exp_we, exp_err;
        logic [38:0] fix;
        k = 0;
        for (int v = 0; v < 128; v++) begin
            if ($countones(v[6:0]) == 3 && k < 32) begin
                tcol[k] = v[6:0];
                k++;
            end
        end
        ph = 0; idle_run = 0; mcls = 0; abort = 1'b0; fix = '0;
        m_ptr = 1; m_corr = 0; m_uncorr = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk("rst_busy", busy_o, 0);
                chk("rst_we", scrub_we_o, 0);
                chk("rst_waddr", scrub_waddr_o, 0);
                chk("rst_wdata", scrub_wdata_o, 0);
                chk("rst_err", uncorr_err_o, 0);
                chk("rst_raddr", scrub_raddr_o, 1);
                chk("rst_corr", corr_cnt_o, 0);
                chk("rst_uncorr", uncorr_cnt_o, 0);
                ph = 0; idle_run = 0; abort = 1'b0;
                m_ptr = 1; m_corr = 0; m_uncorr = 0;
            end else begin
                collide = core_we_i && (core_waddr_i == 5'(m_ptr));
                exp_we = 1'b0; exp_err = 1'b0;
                chk("busy", busy_o, ph != 0);
                chk("raddr", scrub_raddr_o, m_ptr);
                chk("corr_cnt", corr_cnt_o, m_corr);
                chk("uncorr_cnt", uncorr_cnt_o, m_uncorr);
                chk("we_overlap", scrub_we_o & core_we_i, 0);
                case (ph)
                    0: begin
                        abort = 1'b0;
                        if (!en_i) idle_run = 0;
                        else begin
                            idle_run++;
                            if (idle_run == SI) begin ph = 1; idle_run = 0; end
                        end
                    end
                    1: begin
                        mcls = classify(rf[m_ptr], fix);
                        abort = collide;
                        ph = 2;
                    end
                    2: begin
                        abort = abort | collide;
                        if (abort || mcls == 0) begin
                            m_ptr = nextp(m_ptr); ph = 0;
                        end else if (mcls == 2) begin
                            exp_err = 1'b1;
                            if (m_uncorr < SAT) m_uncorr++;
                            m_ptr = nextp(m_ptr); ph = 0;
                        end else ph = 3;
                    end
                    default: begin
                        if (abort || collide) begin
                            m_ptr = nextp(m_ptr); ph = 0;
                        end else if (!core_we_i) begin
                            exp_we = 1'b1;
                            chk("waddr", scrub_waddr_o, m_ptr);
                            chk("wdata", scrub_wdata_o, fix);
                            if (m_corr < SAT) m_corr++;
                            m_ptr = nextp(m_ptr); ph = 0;
                        end
                    end
                endcase
                chk("scrub_we", scrub_we_o, exp_we);
                chk("uncorr_err", uncorr_err_o, exp_err);
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_en(input logic v);
        cyc(); en_i = v;
    endtask

    task automatic core_write(input int a, input logic [38:0] d);
        cyc(); core_we_i = 1'b1; core_waddr_i = 5'(a); core_wdata = d;
        cyc(); core_we_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < 20);
        if (busy_o) chk("timeout_idle", 1, 0);
    endtask

    // Returns at the negedge of the READ cycle of the next check of 'want'.
    task automatic wait_start(input int want, output logic [4:0] a);
        logic prev;
        int n;
        n = 0; a = 5'd0; prev = busy_o;
        forever begin
            @(negedge clk); n++;
            if (busy_o && !prev && (want < 0 || scrub_raddr_o == 5'(want))) begin
                a = scrub_raddr_o;
                return;
            end
            prev = busy_o;
            if (n > 1000) begin
                chk("timeout_start", 1, 0);
                return;
            end
        end
    endtask

    task automatic wait_sig(input string nm, input int which);
        int n;
        n = 0;
        forever begin
            @(negedge clk); n++;
            if ((which == 0 && scrub_we_o) || (which == 1 && uncorr_err_o)) return;
            if (n > 1000) begin
                chk(nm, 1, 0);
                return;
            end
        end
    endtask

    initial begin : stim
        logic [38:0] fx, bad, m;
        logic [4:0]  a;
        int          nw, n;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Hand-computed codewords pin the model's encoder and decoder.
        chk("enc_1", enc(32'h1), 39'h07_0000_0001);
        chk("enc_8", enc(32'h8), 39'h0E_0000_0008);
        chk("enc_3", enc(32'h3), 39'h0C_0000_0003);
        chk("cls_single", classify(39'h07_0000_0009, fx), 1);
        chk("cls_single_fix", fx, 39'h07_0000_0001);
        chk("cls_double", classify(39'h0C_0000_0000, fx), 2);

        for (int i = 0; i < NW; i++) core_write(i, enc(32'h1234_5678 ^ (i * 32'h0101_0101)));

        // Clean pass: visit order 1..31 then wrap to 1.
        set_en(1'b1);
        for (int i = 0; i < NW; i++) begin
            wait_start(-1, a);
            chk("visit_order", a, (i % (NW - 1)) + 1);
        end
        chk("clean_corr", corr_cnt_o, 0);
        chk("clean_uncorr", uncorr_cnt_o, 0);

        // x5 single error, x7 double error.
        set_en(1'b0); wait_idle();
        core_write(5, 39'h07_0000_0009);
        core_write(7, 39'h0C_0000_0000);
        set_en(1'b1);
        wait_sig("timeout_we_x5", 0);
        chk("x5_waddr", scrub_waddr_o, 5);
        chk("x5_wdata", scrub_wdata_o, 39'h07_0000_0001);
        wait_sig("timeout_err_x7", 1);
        chk("x7_raddr", scrub_raddr_o, 7);
        cyc();
        chk("x7_uncorr_cnt", uncorr_cnt_o, 1);
        chk("x7_corr_cnt", corr_cnt_o, 1);
        chk("x7_ptr_next", scrub_raddr_o, 8);

        // x9 correctable with core writes to x12 holding off write-back.
        set_en(1'b0); wait_idle();
        core_write(7, enc(32'h3));
        m = 39'h20;
        bad = enc(32'hCAFE_0000) ^ m;
        core_write(9, bad);
        set_en(1'b1);
        wait_start(9, a);
        cyc();                                  // CHECK
        cyc();                                  // WB
        core_we_i = 1'b1; core_waddr_i = 5'd12; core_wdata = enc(32'h12);
        repeat (3) begin
            @(negedge clk);
            chk("x9_stall_we", scrub_we_o, 0);
            cyc();
        end
        core_we_i = 1'b0;
        @(negedge clk);
        chk("x9_we", scrub_we_o, 1);
        chk("x9_wdata", scrub_wdata_o, enc(32'hCAFE_0000));
        cyc();
        chk("x9_corr_cnt", corr_cnt_o, 2);

        // Same error, core overwrites x9 during CHECK: scrub must back off.
        set_en(1'b0); wait_idle();
        core_write(9, bad);
        set_en(1'b1);
        wait_start(9, a);
        cyc();
        core_we_i = 1'b1; core_waddr_i = 5'd9; core_wdata = enc(32'hCAFE_0000);
        cyc();
        core_we_i = 1'b0;
        nw = 0;
        repeat (6) begin @(negedge clk); if (scrub_we_o) nw++; end
        chk("x9_abort_no_we", nw, 0);
        chk("x9_abort_corr_cnt", corr_cnt_o, 2);
        chk("x9_abort_idle", busy_o, 0);

        // Drive the correction counter past saturation.
        for (int p = 0; p < 9; p++) begin
            set_en(1'b0); wait_idle();
            for (int i = 1; i < NW; i++) core_write(i, enc(32'h0F0F_0000 + i) ^ (39'd1 << i));
            set_en(1'b1);
            nw = 0; n = 0;
            while (nw < NW - 1 && n < (NW - 1) * (SI + 4) + 50) begin
                @(negedge clk); n++;
                if (scrub_we_o) nw++;
            end
            chk("sat_pass_writes", nw, NW - 1);
        end
        cyc();
        chk("corr_saturated", corr_cnt_o, 255);

        // Reset asserted while in write-back.
        set_en(1'b0); wait_idle();
        core_write(3, enc(32'hBEEF) ^ 39'h1);
        set_en(1'b1);
        wait_start(3, a);
        cyc();                                  // CHECK
        cyc();                                  // WB
        rst_ni = 1'b0;
        #1;
        chk("rst_wb_we", scrub_we_o, 0);
        chk("rst_wb_busy", busy_o, 0);
        repeat (2) cyc();
        rst_ni = 1'b1;
        chk("post_rst_ptr", scrub_raddr_o, 1);
        chk("post_rst_corr", corr_cnt_o, 0);
        chk("post_rst_uncorr", uncorr_cnt_o, 0);
        wait_start(-1, a);
        chk("post_rst_first", a, 1);
        repeat (40) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
